control_sequencer: RTL

- Hardwired control unit that sits directly upstream of the datapath.
- Steps the fetch cycle (T0-T2), decodes the opcode in IRVal, and drives every datapath strobe per T-state for the executed instruction.
- Replaces the hand-coded per-instruction state machines in the phase-2 benches; datapath consumes its outputs one-to-one.

---
 rtl/cpu_ctrl_pkg.sv | 81 ++++++++
 rtl/control_sequencer_if.sv | 35 +++
 rtl/opcode_classifier.sv | 46 ++++
 rtl/control_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, sequencer
// states, opcode classes, ALU select positions and the strobe bundle.
package cpu_ctrl_pkg;

    // Opcodes, taken from IRVal[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // Sequencer states: fetch T0-T2, execute T3-T7
    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALTED
    } state_t;

    // Instruction classes sharing one execute sequence
    typedef enum logic [3:0] {
        ALU3, ALUI, ALU2, MULDIV, LD, LDI, ST, BR, JR, IN, OUT, MFHILO, NOP, HALT
    } op_class_t;

    // Bit positions inside the one-hot ALU select vector
    localparam int ALU_W      = 12;
    localparam int ALU_ADD    = 0;
    localparam int ALU_SUB    = 1;
    localparam int ALU_MUL    = 2;
    localparam int ALU_DIV    = 3;
    localparam int ALU_SHR    = 4;
    localparam int ALU_SHL    = 5;
    localparam int ALU_ROR    = 6;
    localparam int ALU_ROL    = 7;
    localparam int ALU_AND    = 8;
    localparam int ALU_OR     = 9;
    localparam int ALU_NEGATE = 10;
    localparam int ALU_NOT    = 11;

    // Every datapath strobe produced in one step
    typedef struct packed {
        logic PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout, Rout;
        logic PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, OUTPUTin, Rin;
        logic Gra, Grb, Grc;
        logic Read, Write, IncPC;
        logic [ALU_W-1:0] alu;
    } ctrl_t;

    // Debug step number shown on tstate; IDLE and HALTED read as 0
    function automatic logic [2:0] step_of(input state_t s);
        case (s)
            T1:      return 3'd1;
            T2:      return 3'd2;
            T3:      return 3'd3;
            T4:      return 3'd4;
            T5:      return 3'd5;
            T6:      return 3'd6;
            T7:      return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: instruction and
// branch flag in, every strobe out.
interface control_sequencer_if #(
    parameter int BITS = 32
);
    logic [BITS-1:0] IRVal;
    logic CON;
    logic PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout, Rout;
    logic PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, OUTPUTin, Rin;
    logic Gra, Grb, Grc;
    logic Read, Write, IncPC;
    logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
    logic run;
    logic [2:0] tstate;

    // Sequencer side
    modport master (
        input  IRVal, CON,
        output PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout, Rout,
        output PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, OUTPUTin, Rin,
        output Gra, Grb, Grc, Read, Write, IncPC,
        output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
        output run, tstate
    );

    // Datapath side
    modport slave (
        output IRVal, CON,
        input  PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout, Rout,
        input  PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, OUTPUTin, Rin,
        input  Gra, Grb, Grc, Read, Write, IncPC,
        input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
        input  run, tstate
    );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational opcode decode: instruction class plus the one-hot ALU
// operation used by that class. Address-forming classes (ld/ldi/st/br)
// carry ADD so the sequencer can use alu_sel uniformly.
module opcode_classifier
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]       opcode,
    output op_class_t        op_class,
    output logic [ALU_W-1:0] alu_sel
);

    // Map opcode to class and ALU op; unknown opcodes behave as nop
    always_comb begin
        op_class = NOP;
        alu_sel  = '0;
        case (opcode)
            OP_LD:   begin op_class = LD;     alu_sel[ALU_ADD]    = 1'b1; end
            OP_LDI:  begin op_class = LDI;    alu_sel[ALU_ADD]    = 1'b1; end
            OP_ST:   begin op_class = ST;     alu_sel[ALU_ADD]    = 1'b1; end
            OP_ADD:  begin op_class = ALU3;   alu_sel[ALU_ADD]    = 1'b1; end
            OP_SUB:  begin op_class = ALU3;   alu_sel[ALU_SUB]    = 1'b1; end
            OP_SHR:  begin op_class = ALU3;   alu_sel[ALU_SHR]    = 1'b1; end
            OP_SHL:  begin op_class = ALU3;   alu_sel[ALU_SHL]    = 1'b1; end
            OP_ROR:  begin op_class = ALU3;   alu_sel[ALU_ROR]    = 1'b1; end
            OP_ROL:  begin op_class = ALU3;   alu_sel[ALU_ROL]    = 1'b1; end
            OP_AND:  begin op_class = ALU3;   alu_sel[ALU_AND]    = 1'b1; end
            OP_OR:   begin op_class = ALU3;   alu_sel[ALU_OR]     = 1'b1; end
            OP_ADDI: begin op_class = ALUI;   alu_sel[ALU_ADD]    = 1'b1; end
            OP_ANDI: begin op_class = ALUI;   alu_sel[ALU_AND]    = 1'b1; end
            OP_ORI:  begin op_class = ALUI;   alu_sel[ALU_OR]     = 1'b1; end
            OP_MUL:  begin op_class = MULDIV; alu_sel[ALU_MUL]    = 1'b1; end
            OP_DIV:  begin op_class = MULDIV; alu_sel[ALU_DIV]    = 1'b1; end
            OP_NEG:  begin op_class = ALU2;   alu_sel[ALU_NEGATE] = 1'b1; end
            OP_NOT:  begin op_class = ALU2;   alu_sel[ALU_NOT]    = 1'b1; end
            OP_BR:   begin op_class = BR;     alu_sel[ALU_ADD]    = 1'b1; end
            OP_JR:   op_class = JR;
            OP_IN:   op_class = IN;
            OP_OUT:  op_class = OUT;
            OP_MFHI: op_class = MFHILO;
            OP_MFLO: op_class = MFHILO;
            OP_HALT: op_class = HALT;
            default: op_class = NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch T0-T2, then the execute sequence of
// the decoded instruction class, driving every datapath strobe per step.
// Outputs are pure decode of the state register (and IRVal/CON), so an
// asynchronous reset clears them in the same cycle.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int BITS = 32,
    parameter int OPW  = 5
) (
    input  logic clk,
    input  logic reset,
    control_sequencer_if.master bus
);

    state_t           state_reg, state_next;
    ctrl_t            ctl;
    op_class_t        op_class;
    logic [ALU_W-1:0] alu_sel;
    logic [OPW-1:0]   opcode;
    logic             unused_ir_bits;

    assign opcode         = bus.IRVal[BITS-1 -: OPW];
    assign unused_ir_bits = ^bus.IRVal[BITS-OPW-1:0];

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (op_class),
        .alu_sel  (alu_sel)
    );

    // State register with asynchronous return to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next state and per-step strobe decode
    always_comb begin
        state_next = T0;
        ctl        = '0;
        case (state_reg)
            IDLE: state_next = T0;
            T0: begin
                ctl.PCout = 1'b1; ctl.MARin = 1'b1; ctl.IncPC = 1'b1; ctl.RZin = 1'b1;
                state_next = T1;
            end
            T1: begin
                ctl.RZout = 1'b1; ctl.PCin = 1'b1; ctl.Read = 1'b1; ctl.MDRin = 1'b1;
                state_next = T2;
            end
            T2: begin
                ctl.MDRout = 1'b1; ctl.IRin = 1'b1;
                state_next = T3;
            end
            T3: begin
                state_next = T4;
                case (op_class)
                    ALU3, ALUI: begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.RYin = 1'b1; end
                    ALU2: begin
                        ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.alu = alu_sel; ctl.RZin = 1'b1;
                    end
                    MULDIV: begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.RYin = 1'b1; end
                    LD, LDI, ST: begin ctl.Grb = 1'b1; ctl.BAout = 1'b1; ctl.RYin = 1'b1; end
                    BR: begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.CONin = 1'b1; end
                    JR: begin
                        ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1;
                        state_next = T0;
                    end
                    IN: begin
                        ctl.INPUTout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
                        state_next = T0;
                    end
                    OUT: begin
                        ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.OUTPUTin = 1'b1;
                        state_next = T0;
                    end
                    MFHILO: begin
                        ctl.HILOout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
                        state_next = T0;
                    end
                    HALT:    state_next = HALTED;
                    default: state_next = T0;
                endcase
            end
            T4: begin
                state_next = T5;
                case (op_class)
                    ALU3, MULDIV: begin
                        ctl.Grc  = (op_class == ALU3);
                        ctl.Grb  = (op_class == MULDIV);
                        ctl.Rout = 1'b1; ctl.alu = alu_sel; ctl.RZin = 1'b1;
                    end
                    ALUI, LD, LDI, ST: begin ctl.Cout = 1'b1; ctl.alu = alu_sel; ctl.RZin = 1'b1; end
                    ALU2: begin
                        ctl.RZout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
                        state_next = T0;
                    end
                    BR:      begin ctl.PCout = 1'b1; ctl.RYin = 1'b1; end
                    default: state_next = T0;
                endcase
            end
            T5: begin
                state_next = T0;
                case (op_class)
                    ALU3, ALUI, LDI: begin ctl.RZout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                    MULDIV: begin ctl.RZout = 1'b1; ctl.HILOin = 1'b1; end
                    LD, ST: begin
                        ctl.RZout = 1'b1; ctl.MARin = 1'b1;
                        state_next = T6;
                    end
                    BR: begin
                        ctl.Cout = 1'b1; ctl.alu = alu_sel; ctl.RZin = 1'b1;
                        state_next = T6;
                    end
                    default: state_next = T0;
                endcase
            end
            T6: begin
                state_next = T0;
                case (op_class)
                    LD: begin ctl.Read = 1'b1; ctl.MDRin = 1'b1; state_next = T7; end
                    ST: begin
                        ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.MDRin = 1'b1;
                        state_next = T7;
                    end
                    // Branch target is committed only when the condition holds
                    BR: begin ctl.RZout = bus.CON; ctl.PCin = bus.CON; end
                    default: state_next = T0;
                endcase
            end
            T7: begin
                state_next = T0;
                case (op_class)
                    LD:      begin ctl.MDRout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                    ST:      ctl.Write = 1'b1;
                    default: ctl.Write = 1'b0;
                endcase
            end
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    assign bus.run    = (state_reg != IDLE) && (state_reg != HALTED);
    assign bus.tstate = step_of(state_reg);

    assign bus.PCout    = ctl.PCout;
    assign bus.MDRout   = ctl.MDRout;
    assign bus.RZout    = ctl.RZout;
    assign bus.HILOout  = ctl.HILOout;
    assign bus.INPUTout = ctl.INPUTout;
    assign bus.Cout     = ctl.Cout;
    assign bus.BAout    = ctl.BAout;
    assign bus.Rout     = ctl.Rout;
    assign bus.PCin     = ctl.PCin;
    assign bus.IRin     = ctl.IRin;
    assign bus.RYin     = ctl.RYin;
    assign bus.RZin     = ctl.RZin;
    assign bus.MARin    = ctl.MARin;
    assign bus.MDRin    = ctl.MDRin;
    assign bus.HILOin   = ctl.HILOin;
    assign bus.CONin    = ctl.CONin;
    assign bus.OUTPUTin = ctl.OUTPUTin;
    assign bus.Rin      = ctl.Rin;
    assign bus.Gra      = ctl.Gra;
    assign bus.Grb      = ctl.Grb;
    assign bus.Grc      = ctl.Grc;
    assign bus.Read     = ctl.Read;
    assign bus.Write    = ctl.Write;
    assign bus.IncPC    = ctl.IncPC;
    assign bus.ADD      = ctl.alu[ALU_ADD];
    assign bus.SUB      = ctl.alu[ALU_SUB];
    assign bus.MUL      = ctl.alu[ALU_MUL];
    assign bus.DIV      = ctl.alu[ALU_DIV];
    assign bus.SHR      = ctl.alu[ALU_SHR];
    assign bus.SHL      = ctl.alu[ALU_SHL];
    assign bus.ROR      = ctl.alu[ALU_ROR];
    assign bus.ROL      = ctl.alu[ALU_ROL];
    assign bus.AND      = ctl.alu[ALU_AND];
    assign bus.OR       = ctl.alu[ALU_OR];
    assign bus.NEGATE   = ctl.alu[ALU_NEGATE];
    assign bus.NOT      = ctl.alu[ALU_NOT];

endmodule
